// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the memory-access stage and its helpers:
//    - operation encodings carried on in_op
//    - FSM state encodings of the stage controller
//    - default parameter values and a counter-width helper
package mem_pkg;

   localparam int MEM_AW_DEFAULT      = 32;
   localparam int MEM_TIMEOUT_DEFAULT = 16;

   // Operation encodings; the reserved code is handled like a pass.
   typedef enum logic [1:0] {
      MEM_OP_PASS  = 2'b00,
      MEM_OP_LOAD  = 2'b01,
      MEM_OP_STORE = 2'b10,
      MEM_OP_RSVD  = 2'b11
   } mem_op_e;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } mem_state_e;

   // Width needed to count 0 .. n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt
// Cycle counter used to bound how long the stage waits for a memory
// acknowledge. The count restarts on clear, advances while enable is high
// and saturates at TIMEOUT-1, where tc (terminal count) is raised.
//
// Ports:
//    clk     in   clock, all updates on posedge
//    reset   in   synchronous active-high reset, count returns to zero
//    clear   in   restart the count at zero (wins over enable)
//    enable  in   advance the count by one this cycle
//    tc      out  count has reached TIMEOUT-1
module mem_timeout_cnt
   import mem_pkg::*;
#(
   parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT,
   parameter int CW      = cnt_width(TIMEOUT)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   logic [CW-1:0] count;

   // Count register; holding at the terminal value keeps tc asserted
   // instead of wrapping back to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !tc) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory-access stage of the multi-cycle CPU. Takes the registered ALU
// result from the execute stage and either passes it straight to write-back
// or uses it as a byte address for a word load/store over a req/ack data
// memory handshake. Every accepted operation yields one write-back record.
//
// Optional feature (compile-time macro MEM_STAGE_ALIGN_CHECK_EN):
//    defined   - a load/store whose address has bits [1:0] != 0 is rejected
//                without touching memory; it returns wb_err=1 and the
//                offending address as wb_data.
//    undefined - no alignment check, the address is issued unchanged.
//
// Ports:
//    clk, reset            clock and synchronous active-high reset
//    in_valid/in_ready     execute-stage handshake (transfer when both high)
//    in_op                 00 pass, 01 load, 10 store, 11 pass
//    in_result             ALU result: address (load/store) or data (pass)
//    in_wdata, in_rd       store data and destination register
//    mem_req/mem_we        memory request (held until ack) and write select
//    mem_addr/mem_wdata    request address and store data, stable during req
//    mem_ack/mem_rdata     one-cycle acknowledge with read data
//    wb_valid              one-cycle pulse marking a write-back record
//    wb_we/wb_rd/wb_data   register write enable, destination and value
//    wb_err                access aborted (timeout or misalignment)
module mem_stage
   import mem_pkg::*;
#(
   parameter int AW      = MEM_AW_DEFAULT,
   parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_op,
   input  logic [AW-1:0] in_result,
   input  logic [AW-1:0] in_wdata,
   input  logic [4:0]    in_rd,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [AW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [AW-1:0] mem_rdata,
   output logic          wb_valid,
   output logic          wb_we,
   output logic [4:0]    wb_rd,
   output logic [AW-1:0] wb_data,
   output logic          wb_err
);

   mem_state_e    state_q, state_d;
   logic [4:0]    rd_q, rd_d;
   logic          mem_req_d, mem_we_d;
   logic [AW-1:0] mem_addr_d, mem_wdata_d;
   logic          wb_we_d, wb_err_d;
   logic [4:0]    wb_rd_d;
   logic [AW-1:0] wb_data_d;
   logic          cnt_clear, cnt_enable, cnt_tc;
   logic          is_mem_op, is_store, misaligned;

   assign is_store  = (in_op == MEM_OP_STORE);
   assign is_mem_op = (in_op == MEM_OP_LOAD) || is_store;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
   assign misaligned = (in_result[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // Handshake flags depend only on the state, never on in_valid.
   assign in_ready = (state_q == ST_IDLE);
   assign wb_valid = (state_q == ST_RESP);

   mem_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .tc     (cnt_tc)
   );

   // Next-state and next-output logic. Every registered output holds its
   // value unless the current state explicitly updates it, which is what
   // keeps the write-back record stable between RESP visits.
   always_comb begin
      state_d     = state_q;
      rd_d        = rd_q;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      wb_we_d     = wb_we;
      wb_rd_d     = wb_rd;
      wb_data_d   = wb_data;
      wb_err_d    = wb_err;
      cnt_clear   = 1'b0;
      cnt_enable  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (is_mem_op && misaligned) begin
                  state_d   = ST_RESP;
                  wb_we_d   = 1'b0;
                  wb_err_d  = 1'b1;
                  wb_rd_d   = in_rd;
                  wb_data_d = in_result;
               end else if (is_mem_op) begin
                  state_d     = ST_ACCESS;
                  mem_req_d   = 1'b1;
                  mem_we_d    = is_store;
                  mem_addr_d  = in_result;
                  mem_wdata_d = in_wdata;
                  rd_d        = in_rd;
                  cnt_clear   = 1'b1;
               end else begin
                  state_d   = ST_RESP;
                  wb_we_d   = 1'b1;
                  wb_err_d  = 1'b0;
                  wb_rd_d   = in_rd;
                  wb_data_d = in_result;
               end
            end
         end

         ST_ACCESS: begin
            cnt_enable = 1'b1;
            // Acknowledge is tested first so a late ack on the terminal
            // cycle still completes the access without an error.
            if (mem_ack) begin
               state_d   = ST_RESP;
               mem_req_d = 1'b0;
               wb_we_d   = !mem_we;
               wb_err_d  = 1'b0;
               wb_rd_d   = rd_q;
               wb_data_d = mem_we ? '0 : mem_rdata;
            end else if (cnt_tc) begin
               state_d   = ST_RESP;
               mem_req_d = 1'b0;
               wb_we_d   = 1'b0;
               wb_err_d  = 1'b1;
               wb_rd_d   = rd_q;
               wb_data_d = '0;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers. Reset discards any in-flight access, so
   // an interrupted request never produces a write-back pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rd_q      <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wb_we     <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         wb_err    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         wb_we     <= wb_we_d;
         wb_rd     <= wb_rd_d;
         wb_data   <= wb_data_d;
         wb_err    <= wb_err_d;
      end
   end

endmodule
